lif_tdm_scheduler: RTL and testbench

Time-multiplexed controller that shares one leak/integrate/fire update datapath across N_NEURONS virtual LIF neurons. On each start pulse it performs a timestep sweep:
- fetches each neuron's input current through an index/data interface
- applies leak, integration, threshold and refractory rules
- writes back membrane state and raises that neuron's spike bit
It sits between the input-current pins and the spike outputs in the neuromorphic top level, with a small register interface for runtime configuration.

---
 rtl/lif_tdm_scheduler.sv | 164 ++++++++++++++++
 tb/tb_lif_tdm_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_tdm_scheduler.sv
// Time-multiplexed LIF update engine: one datapath sweeps N_NEURONS neurons, 2*N_NEURONS+1 cycles per sweep.
// No backpressure: cur_in is taken on the LOAD edge; ena low freezes everything and masks done/state_vld.
module lif_tdm_scheduler #(
  parameter int N_NEURONS = 4,
  parameter int WIDTH     = 8,
  parameter int IDX_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 start,
  output logic [IDX_W-1:0]     cur_idx,
  input  logic [WIDTH-1:0]     cur_in,
  input  logic                 cfg_we,
  input  logic [1:0]           cfg_addr,
  input  logic [WIDTH-1:0]     cfg_data,
  output logic                 busy,
  output logic                 done,
  output logic [N_NEURONS-1:0] spike_vec,
  output logic [WIDTH-1:0]     state_out,
  output logic [IDX_W-1:0]     state_idx,
  output logic                 state_vld
);

  localparam logic [WIDTH-1:0] THR_RST = WIDTH'(200);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_UPDATE, S_DONE} state_e;

  state_e               fsm_q;
  logic [IDX_W-1:0]     idx_q;
  logic [WIDTH-1:0]     cur_q;
  logic [WIDTH-1:0]     mem_q  [N_NEURONS];
  logic [3:0]           refr_q [N_NEURONS];
  logic [N_NEURONS-1:0] spike_q;
  logic [WIDTH-1:0]     thr_q, sh_thr_q;
  logic [2:0]           leak_q, sh_leak_q;
  logic [3:0]           rp_q, sh_rp_q;
  logic                 busy_q, done_q, vld_q;
  logic [WIDTH-1:0]     st_out_q;
  logic [IDX_W-1:0]     st_idx_q;

  logic [WIDTH-1:0]     mem_sel, refr_unused_w, leak_amt, sum_sat;
  logic [3:0]           refr_sel;
  logic [WIDTH:0]       sum_ext;
  logic [WIDTH-1:0]     mem_d;
  logic [3:0]           refr_d;
  logic                 fire_d;
  logic                 last_idx;

  assign last_idx      = (idx_q == IDX_W'(N_NEURONS - 1));
  assign refr_unused_w = '0;

  // Update datapath for the neuron currently addressed by idx_q, using the shadow config.
  always_comb begin
    mem_sel  = mem_q[idx_q];
    refr_sel = refr_q[idx_q];
    leak_amt = '0;
    if (sh_leak_q != 3'd0) leak_amt = mem_sel >> sh_leak_q;
    sum_ext  = {1'b0, mem_sel} - {1'b0, leak_amt} + {1'b0, cur_q};
    sum_sat  = sum_ext[WIDTH] ? {WIDTH{1'b1}} : sum_ext[WIDTH-1:0];
    mem_d    = sum_sat;
    refr_d   = 4'd0;
    fire_d   = 1'b0;
    if (refr_sel != 4'd0) begin
      mem_d  = refr_unused_w;
      refr_d = refr_sel - 4'd1;
    end else if (sum_sat >= sh_thr_q) begin
      mem_d  = '0;
      refr_d = sh_rp_q;
      fire_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q     <= S_IDLE;
      idx_q     <= '0;
      cur_q     <= '0;
      spike_q   <= '0;
      thr_q     <= THR_RST;
      leak_q    <= 3'd1;
      rp_q      <= 4'd2;
      sh_thr_q  <= THR_RST;
      sh_leak_q <= 3'd1;
      sh_rp_q   <= 4'd2;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      vld_q     <= 1'b0;
      st_out_q  <= '0;
      st_idx_q  <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        mem_q[i]  <= '0;
        refr_q[i] <= '0;
      end
    end else if (!ena) begin
      // Pulses are dropped while frozen so they are not seen twice on resume.
      done_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      vld_q  <= 1'b0;
      if (cfg_we) begin
        case (cfg_addr)
          2'd0: thr_q  <= cfg_data;
          2'd1: leak_q <= cfg_data[2:0];
          2'd2: rp_q   <= cfg_data[3:0];
          default: begin
            if (fsm_q == S_IDLE) begin
              spike_q <= '0;
              for (int i = 0; i < N_NEURONS; i++) begin
                mem_q[i]  <= '0;
                refr_q[i] <= '0;
              end
            end
          end
        endcase
      end
      case (fsm_q)
        S_IDLE: begin
          if (start) begin
            fsm_q     <= S_LOAD;
            idx_q     <= '0;
            busy_q    <= 1'b1;
            sh_thr_q  <= thr_q;
            sh_leak_q <= leak_q;
            sh_rp_q   <= rp_q;
          end
        end
        S_LOAD: begin
          cur_q <= cur_in;
          fsm_q <= S_UPDATE;
        end
        S_UPDATE: begin
          mem_q[idx_q]   <= mem_d;
          refr_q[idx_q]  <= refr_d;
          spike_q[idx_q] <= fire_d;
          st_out_q       <= mem_d;
          st_idx_q       <= idx_q;
          vld_q          <= 1'b1;
          if (last_idx) begin
            fsm_q  <= S_DONE;
            done_q <= 1'b1;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
            fsm_q <= S_LOAD;
          end
        end
        default: begin
          fsm_q  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign cur_idx   = idx_q;
  assign busy      = busy_q;
  assign done      = done_q & ena;
  assign state_vld = vld_q & ena;
  assign spike_vec = spike_q;
  assign state_out = st_out_q;
  assign state_idx = st_idx_q;

endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// Directed plus randomized sweeps checked against an arithmetic LIF model of the four neurons.
module tb_lif_tdm_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       start = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = 2'd0;
  logic [7:0] cfg_data = 8'd0;
  logic [1:0] cur_idx;
  logic [7:0] cur_in;
  logic       busy, done, state_vld;
  logic [3:0] spike_vec;
  logic [7:0] state_out;
  logic [1:0] state_idx;

  logic [7:0] cur_tab [4];
  assign cur_in = cur_tab[cur_idx];

  int checks = 0;
  int passed = 0;

  int     m_mem [4];
  int     m_refr [4];
  bit [3:0] m_spk;
  int     thr, ls, rp;

  lif_tdm_scheduler #(.N_NEURONS(4), .WIDTH(8), .IDX_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
    .cur_idx(cur_idx), .cur_in(cur_in),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .busy(busy), .done(done), .spike_vec(spike_vec),
    .state_out(state_out), .state_idx(state_idx), .state_vld(state_vld)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin
      m_mem[i]  = 0;
      m_refr[i] = 0;
    end
    m_spk = 4'b0;
    thr = 200;
    ls  = 1;
    rp  = 2;
  endtask

  task automatic m_cfg(input int a, input int d, input bit idle);
    case (a)
      0: thr = d & 255;
      1: ls  = d & 7;
      2: rp  = d & 15;
      default: if (idle) begin
        for (int i = 0; i < 4; i++) begin
          m_mem[i]  = 0;
          m_refr[i] = 0;
        end
        m_spk = 4'b0;
      end
    endcase
  endtask

  task automatic cfg_wr(input int a, input int d);
    cfg_we = 1'b1;
    cfg_addr = 2'(a);
    cfg_data = 8'(d);
    tick();
    cfg_we = 1'b0;
    m_cfg(a, d, 1'b1);
  endtask

  // One sweep from idle; optional freeze, mid-sweep config write and stray start (k = busy cycle number).
  task automatic sweep(input int frz_at, input int frz_len, input int cfg_at,
                       input int cfg_a, input int cfg_d, input int st_at);
    int s_thr, s_ls, s_rp, leak, sum, k, nv;
    int exp_st [4];
    bit exp_sp [4];
    bit got_done;
    s_thr = thr;
    s_ls  = ls;
    s_rp  = rp;
    for (int i = 0; i < 4; i++) begin
      if (m_refr[i] != 0) begin
        m_refr[i]--;
        m_mem[i]  = 0;
        exp_sp[i] = 1'b0;
      end else begin
        leak = (s_ls == 0) ? 0 : m_mem[i] / (1 << s_ls);
        sum  = m_mem[i] - leak + int'(cur_tab[i]);
        if (sum > 255) sum = 255;
        if (sum >= s_thr) begin
          exp_sp[i] = 1'b1;
          m_mem[i]  = 0;
          m_refr[i] = s_rp;
        end else begin
          exp_sp[i] = 1'b0;
          m_mem[i]  = sum;
        end
      end
      exp_st[i] = m_mem[i];
      m_spk[i]  = exp_sp[i];
    end

    start = 1'b1;
    tick();
    start = 1'b0;
    k = 1;
    nv = 0;
    got_done = 1'b0;
    while (!got_done && k <= 60) begin
      chk("busy", busy, 1);
      if (state_vld === 1'b1) begin
        if (nv < 4) begin
          chk("vld_idx", state_idx, nv);
          chk("state_out", state_out, exp_st[nv]);
          chk("spike_bit", spike_vec[state_idx], exp_sp[nv]);
        end else begin
          chk("extra_vld", nv, 3);
        end
        nv++;
      end
      if (done === 1'b1) begin
        got_done = 1'b1;
        chk("done_cycle", k, 9 + frz_len);
        chk("vld_count", nv, 4);
      end
      if (k == frz_at) begin
        start = 1'b0;
        cfg_we = 1'b0;
        ena = 1'b0;
        repeat (frz_len) begin
          tick();
          k++;
          chk("frz_done", done, 0);
          chk("frz_vld", state_vld, 0);
        end
        ena = 1'b1;
        #1;
        chk("resume_vld", state_vld, 0);
        chk("resume_done", done, 0);
      end else begin
        start = (k == st_at);
        cfg_we = (k == cfg_at);
        cfg_addr = 2'(cfg_a);
        cfg_data = 8'(cfg_d);
        if (k == cfg_at) m_cfg(cfg_a, cfg_d, 1'b0);
      end
      tick();
      k++;
    end
    start = 1'b0;
    cfg_we = 1'b0;
    if (!got_done) chk("done_timeout", 0, 1);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("spike_vec", spike_vec, m_spk);
    tick();
    chk("idle_busy2", busy, 0);
  endtask

  initial begin
    int fa, fl, ca, sa;
    for (int i = 0; i < 4; i++) cur_tab[i] = 8'd0;
    m_reset();
    rst_n = 1'b0;
    ena = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_vld", state_vld, 0);
    chk("rst_cur_idx", cur_idx, 0);
    chk("rst_state_out", state_out, 0);
    chk("rst_state_idx", state_idx, 0);
    chk("rst_spike_vec", spike_vec, 0);

    // All-zero currents.
    sweep(-1, 0, -1, 0, 0, -1);

    // Neuron 0 driven with 150 for five sweeps: integrate, fire, two refractory sweeps, integrate.
    cur_tab[0] = 8'd150;
    sweep(-1, 0, -1, 0, 0, -1);
    chk("n0_s1_state", state_out, 0);
    sweep(-1, 0, -1, 0, 0, -1);
    chk("n0_s2_spike", spike_vec[0], 1);
    sweep(-1, 0, -1, 0, 0, -1);
    chk("n0_s3_spike", spike_vec[0], 0);
    sweep(-1, 0, -1, 0, 0, -1);
    sweep(-1, 0, -1, 0, 0, -1);
    chk("n0_s5_spike", spike_vec[0], 0);

    // Saturation at 255 meets threshold 255.
    cfg_wr(3, 0);
    cfg_wr(0, 255);
    cfg_wr(1, 0);
    cur_tab[0] = 8'd0;
    cur_tab[1] = 8'd200;
    sweep(-1, 0, -1, 0, 0, -1);
    cur_tab[1] = 8'd100;
    sweep(-1, 0, -1, 0, 0, -1);
    chk("sat_spike1", spike_vec[1], 1);

    // Threshold write mid-sweep only affects the following sweep.
    cfg_wr(3, 0);
    cfg_wr(0, 200);
    cfg_wr(1, 1);
    cur_tab[1] = 8'd0;
    cur_tab[3] = 8'd150;
    sweep(-1, 0, 4, 0, 100, -1);
    chk("cfg_old_thr", spike_vec[3], 0);
    sweep(-1, 0, -1, 0, 0, -1);
    chk("cfg_new_thr", spike_vec[3], 1);

    // Stray start while busy, 3-cycle freeze, then start coincident with DONE.
    cfg_wr(0, 200);
    cur_tab[0] = 8'd40;
    cur_tab[1] = 8'd90;
    cur_tab[2] = 8'd120;
    cur_tab[3] = 8'd7;
    sweep(5, 3, -1, 0, 0, 3);
    sweep(-1, 0, -1, 0, 0, 9);

    // Reset during UPDATE of neuron 2.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_vld", state_vld, 0);
    chk("arst_cur_idx", cur_idx, 0);
    chk("arst_state_out", state_out, 0);
    chk("arst_state_idx", state_idx, 0);
    chk("arst_spike_vec", spike_vec, 0);
    m_reset();
    tick();
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      chk("post_rst_done", done, 0);
      chk("post_rst_busy", busy, 0);
    end

    // Build nonzero state and refractory neurons, clear while idle, then integrate from zero.
    cur_tab[0] = 8'd250;
    cur_tab[1] = 8'd100;
    cur_tab[2] = 8'd250;
    cur_tab[3] = 8'd0;
    sweep(-1, 0, -1, 0, 0, -1);
    cfg_wr(3, 0);
    chk("clr_spike_vec", spike_vec, 0);
    for (int i = 0; i < 4; i++) cur_tab[i] = 8'd10;
    sweep(-1, 0, -1, 0, 0, -1);
    chk("clr_last_state", state_out, 10);

    // Threshold 0 fires every non-refractory neuron.
    cfg_wr(3, 0);
    cfg_wr(0, 0);
    for (int i = 0; i < 4; i++) cur_tab[i] = 8'($urandom_range(0, 255));
    sweep(-1, 0, -1, 0, 0, -1);
    chk("thr0_all", spike_vec, 4'hF);
    cfg_wr(0, 200);

    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < 4; i++) cur_tab[i] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 2) == 0) begin
        fa = int'($urandom_range(0, 3));
        if (fa == 0) cfg_wr(0, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255)));
        else cfg_wr(fa, int'($urandom_range(0, 255)));
      end
      if ($urandom_range(0, 3) == 0) begin
        fa = int'($urandom_range(1, 8));
        fl = int'($urandom_range(1, 3));
      end else begin
        fa = -1;
        fl = 0;
      end
      ca = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8)) : -1;
      sa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 9 + fl)) : -1;
      sweep(fa, fl, ca, int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), sa);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
